// File: rtl/dc_pkg.sv
// Constants and helpers shared by the read and write sides of the EVR
// delay-compensation event/timestamp FIFO.
package dc_pkg;

    localparam int unsigned FIFO36_RD_LATENCY = 2;

    // Physical FIFO36 port width that holds a logical word of w bits.
    function automatic int unsigned fifo36_width(input int unsigned w);
        if (w <= 4)       return 4;
        else if (w <= 8)  return 9;
        else if (w <= 16) return 18;
        else if (w <= 32) return 36;
        else              return 72;
    endfunction

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of the FIFO read engine.
interface fifo_stream_reader_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LVL_W = 3
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_d_out;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [LVL_W-1:0] buf_level;

    modport master (
        input  fifo_empty, fifo_d_out, m_ready,
        output fifo_rd_en, m_data, m_valid, buf_level
    );

    modport slave (
        output fifo_empty, fifo_d_out, m_ready,
        input  fifo_rd_en, m_data, m_valid, buf_level
    );
endinterface

// File: rtl/dc_sync_buf.sv
// Single-clock circular buffer with push/pop and occupancy level; the head
// entry is presented straight from storage registers.
module dc_sync_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      level_q, level_d;
    logic             do_pop;

    assign valid_o = (level_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_i, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && level_q == DEPTH_L));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the dual-clock EVR event/timestamp FIFO: credit-gated
// read enables, in-flight tracking and a local buffer feeding a stream.
module fifo_stream_reader
    import dc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_LATENCY = FIFO36_RD_LATENCY,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_stream_reader_if.master bus
);
    localparam int unsigned LW = lvl_width(BUF_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(BUF_DEPTH);

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [LW-1:0]         inflight_cnt;
    logic [LW-1:0]         level;
    logic [LW-1:0]         credit;
    logic                  rd_en;
    logic                  capture;
    logic                  pop;
    logic                  head_valid;
    logic [WIDTH-1:0]      head_data;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++)
            inflight_cnt = inflight_cnt + LW'(inflight_q[i]);
    end

    // Credit counts words already buffered plus words still in the FIFO
    // output pipeline, so a word can never arrive without a free slot.
    assign credit  = DEPTH_L - level - inflight_cnt;
    assign rd_en   = rst_n & ~bus.fifo_empty & (credit != '0);
    assign capture = inflight_q[RD_LATENCY-1];
    assign pop     = head_valid & bus.m_ready;

    // Shift towards the MSB; the cast drops the oldest bit and covers RD_LATENCY=1.
    assign inflight_d = RD_LATENCY'({inflight_q, rd_en});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= '0;
        else        inflight_q <= inflight_d;
    end

    dc_sync_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture),
        .data_i  (bus.fifo_d_out),
        .pop_i   (pop),
        .head_o  (head_data),
        .valid_o (head_valid),
        .level_o (level)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_data     = head_data;
    assign bus.m_valid    = head_valid;
    assign bus.buf_level  = level;

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, level} + {1'b0, inflight_cnt}) <= {1'b0, DEPTH_L});
    a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
        rd_en |-> !bus.fifo_empty);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: emulates the FIFO read pipeline and
// predicts the stream from a queue-based reference of the credit rules.
module tb_fifo_stream_reader;
    localparam int unsigned W    = 32;
    localparam int unsigned LAT0 = 2;
    localparam int unsigned DEP0 = 4;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned DEP1 = 2;
    localparam int unsigned LW0  = $clog2(DEP0) + 1;
    localparam int unsigned LW1  = $clog2(DEP1) + 1;

    typedef struct packed {
        logic [31:0]  due;
        logic [W-1:0] word;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.WIDTH(W), .LVL_W(LW0)) bus0 ();
    fifo_stream_reader_if #(.WIDTH(W), .LVL_W(LW1)) bus1 ();

    fifo_stream_reader #(.WIDTH(W), .RD_LATENCY(LAT0), .BUF_DEPTH(DEP0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master));
    fifo_stream_reader #(.WIDTH(W), .RD_LATENCY(LAT1), .BUF_DEPTH(DEP1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master));

    logic         empty_v [2];
    logic [W-1:0] dout_v  [2];
    logic         ready_v [2];

    assign bus0.fifo_empty = empty_v[0];
    assign bus0.fifo_d_out = dout_v[0];
    assign bus0.m_ready    = ready_v[0];
    assign bus1.fifo_empty = empty_v[1];
    assign bus1.fifo_d_out = dout_v[1];
    assign bus1.m_ready    = ready_v[1];

    // reference state: FIFO contents, reads in flight, local buffer
    logic [W-1:0] src   [2][$];
    rd_t          pend  [2][$];
    logic [W-1:0] mbuf  [2][$];
    logic [W-1:0] deliv [2][$];
    logic [W-1:0] sent  [2][$];

    int          lat [2];
    int          dep [2];
    int          rdy_cfg [2];
    int          emp_cfg [2];
    int          first_rd [2];
    int          first_valid [2];
    int          last_valid [2];
    int          rd_cnt [2];
    int          valid_cnt [2];
    int unsigned cyc;
    int          total;
    int          bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic obs_rd(input int k);
        return (k == 0) ? bus0.fifo_rd_en : bus1.fifo_rd_en;
    endfunction
    function automatic logic obs_valid(input int k);
        return (k == 0) ? bus0.m_valid : bus1.m_valid;
    endfunction
    function automatic logic [W-1:0] obs_data(input int k);
        return (k == 0) ? bus0.m_data : bus1.m_data;
    endfunction
    function automatic int obs_lvl(input int k);
        return (k == 0) ? int'(bus0.buf_level) : int'(bus1.buf_level);
    endfunction

    task automatic phase_start(input int k);
        first_rd[k]    = -1;
        first_valid[k] = -1;
        last_valid[k]  = -1;
        rd_cnt[k]      = 0;
        valid_cnt[k]   = 0;
        deliv[k].delete();
    endtask

    task automatic check_model(input int k);
        int   credit;
        logic exp_rd;
        logic exp_v;
        rd_t  r;
        credit = dep[k] - mbuf[k].size() - pend[k].size();
        exp_rd = !empty_v[k] && credit > 0;
        exp_v  = mbuf[k].size() != 0;
        check_eq($sformatf("rd_en[%0d]", k), 64'(obs_rd(k)), 64'(exp_rd));
        check_eq($sformatf("rd_while_empty[%0d]", k), 64'(obs_rd(k) & empty_v[k]), 64'd0);
        check_eq($sformatf("m_valid[%0d]", k), 64'(obs_valid(k)), 64'(exp_v));
        check_eq($sformatf("buf_level[%0d]", k), 64'(obs_lvl(k)), 64'(mbuf[k].size()));
        check_eq($sformatf("lvl_bound[%0d]", k), 64'(obs_lvl(k) <= dep[k]), 64'd1);
        if (exp_v) check_eq($sformatf("m_data[%0d]", k), 64'(obs_data(k)), 64'(mbuf[k][0]));
        if (obs_rd(k)) begin
            rd_cnt[k]++;
            if (first_rd[k] < 0) first_rd[k] = int'(cyc);
        end
        if (obs_valid(k)) begin
            valid_cnt[k]++;
            last_valid[k] = int'(cyc);
            if (first_valid[k] < 0) first_valid[k] = int'(cyc);
            if (ready_v[k]) deliv[k].push_back(obs_data(k));
        end
        // end-of-cycle effects: pop, capture of a due read, new read
        if (exp_v && ready_v[k]) void'(mbuf[k].pop_front());
        if (pend[k].size() != 0 && pend[k][0].due == cyc) begin
            r = pend[k].pop_front();
            mbuf[k].push_back(r.word);
        end
        if (exp_rd) begin
            r.due  = cyc + 32'(lat[k]);
            r.word = src[k].pop_front();
            pend[k].push_back(r);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            ready_v[k] = (rdy_cfg[k] == 2) ? 1'($urandom_range(0, 1)) : (rdy_cfg[k] == 1);
            empty_v[k] = (src[k].size() == 0) || (emp_cfg[k] != 0 && $urandom_range(0, 3) == 0);
            dout_v[k]  = (pend[k].size() != 0 && pend[k][0].due == cyc) ? pend[k][0].word : W'($urandom());
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_model(k);
    endtask

    task automatic run_until(input int k, input int n, input int budget);
        int spent = 0;
        while (deliv[k].size() < n && spent < budget) begin
            cycle();
            spent++;
        end
        check_eq($sformatf("delivered[%0d]", k), 64'(deliv[k].size()), 64'(n));
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            src[k].delete();
            pend[k].delete();
            mbuf[k].delete();
        end
    endtask

    initial begin
        int unsigned c0;
        int          spent;
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat[0] = LAT0; dep[0] = DEP0;
        lat[1] = LAT1; dep[1] = DEP1;
        for (int k = 0; k < 2; k++) begin
            empty_v[k] = 1'b1;
            dout_v[k]  = '0;
            ready_v[k] = 1'b0;
            rdy_cfg[k] = 0;
            emp_cfg[k] = 0;
            phase_start(k);
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_rd_en[%0d]", k), 64'(obs_rd(k)), 64'd0);
            check_eq($sformatf("rst_valid[%0d]", k), 64'(obs_valid(k)), 64'd0);
            check_eq($sformatf("rst_data[%0d]", k), 64'(obs_data(k)), 64'd0);
            check_eq($sformatf("rst_level[%0d]", k), 64'(obs_lvl(k)), 64'd0);
        end
        rst_n = 1'b1;

        // first word latency
        src[0].push_back(32'hA5A5_0001);
        rdy_cfg[0] = 1;
        phase_start(0);
        c0 = cyc + 1;
        run_until(0, 1, 20);
        check_eq("first_rd_cycle", 64'(first_rd[0] - int'(c0)), 64'd0);
        check_eq("first_valid_cycle", 64'(first_valid[0] - int'(c0)), 64'd3);
        check_eq("first_word", 64'(deliv[0][0]), 64'h0000_0000_A5A5_0001);

        // streaming 16 words
        for (int i = 0; i < 16; i++) src[0].push_back(W'(i));
        phase_start(0);
        c0 = cyc + 1;
        run_until(0, 16, 100);
        check_eq("stream_first_valid", 64'(first_valid[0] - int'(c0)), 64'd3);
        check_eq("stream_span", 64'(last_valid[0] - first_valid[0]), 64'd15);
        check_eq("stream_valid_cnt", 64'(valid_cnt[0]), 64'd16);
        for (int i = 0; i < 16; i++)
            if (i < deliv[0].size()) check_eq("stream_order", 64'(deliv[0][i]), 64'(i));

        // back-pressure
        rdy_cfg[0] = 0;
        for (int i = 0; i < 10; i++) src[0].push_back(W'(i));
        phase_start(0);
        repeat (20) cycle();
        check_eq("bp_rd_pulses", 64'(rd_cnt[0]), 64'd4);
        check_eq("bp_level", 64'(obs_lvl(0)), 64'd4);
        check_eq("bp_data", 64'(obs_data(0)), 64'd0);
        rdy_cfg[0] = 1;
        run_until(0, 10, 100);
        for (int i = 0; i < 10; i++)
            if (i < deliv[0].size()) check_eq("bp_order", 64'(deliv[0][i]), 64'(i));

        // reset with words both in flight and buffered
        rdy_cfg[0] = 0;
        for (int i = 0; i < 10; i++) src[0].push_back(W'(100 + i));
        phase_start(0);
        spent = 0;
        while (!(pend[0].size() >= 1 && mbuf[0].size() >= 2) && spent < 20) begin
            cycle();
            spent++;
        end
        check_eq("mid_reset_setup", 64'(spent < 20), 64'd1);
        @(posedge clk);
        #2;
        check_eq("pre_reset_level", 64'(obs_lvl(0)), 64'(mbuf[0].size()));
        rst_n = 1'b0;
        #1;
        check_eq("async_rd_en", 64'(obs_rd(0)), 64'd0);
        check_eq("async_valid", 64'(obs_valid(0)), 64'd0);
        check_eq("async_data", 64'(obs_data(0)), 64'd0);
        check_eq("async_level", 64'(obs_lvl(0)), 64'd0);
        clear_model();
        empty_v[0] = 1'b1;
        empty_v[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        src[0].push_back(32'h0000_0BEE);
        src[0].push_back(32'h0000_0BEF);
        src[0].push_back(32'h0000_0BF0);
        rdy_cfg[0] = 1;
        phase_start(0);
        run_until(0, 3, 30);
        check_eq("post_reset_first", 64'(deliv[0][0]), 64'h0BEE);
        if (deliv[0].size() == 3) check_eq("post_reset_last", 64'(deliv[0][2]), 64'h0BF0);

        // RD_LATENCY=1, BUF_DEPTH=2 instance
        for (int i = 0; i < 8; i++) src[1].push_back(W'(32'h100 + i));
        rdy_cfg[1] = 1;
        phase_start(1);
        c0 = cyc + 1;
        run_until(1, 8, 60);
        check_eq("l1_first_rd", 64'(first_rd[1] - int'(c0)), 64'd0);
        check_eq("l1_first_valid", 64'(first_valid[1] - int'(c0)), 64'd2);
        for (int i = 0; i < 8; i++)
            if (i < deliv[1].size()) check_eq("l1_order", 64'(deliv[1][i]), 64'(32'h100 + i));

        // random empty/ready on both instances
        for (int k = 0; k < 2; k++) begin
            sent[k].delete();
            for (int i = 0; i < ((k == 0) ? 1000 : 300); i++) begin
                logic [W-1:0] w;
                w = W'($urandom());
                src[k].push_back(w);
                sent[k].push_back(w);
            end
            rdy_cfg[k] = 2;
            emp_cfg[k] = 1;
            phase_start(k);
        end
        spent = 0;
        while ((deliv[0].size() < 1000 || deliv[1].size() < 300) && spent < 20000) begin
            cycle();
            spent++;
        end
        check_eq("rand_cnt0", 64'(deliv[0].size()), 64'd1000);
        check_eq("rand_cnt1", 64'(deliv[1].size()), 64'd300);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < deliv[k].size() && i < sent[k].size(); i++)
                check_eq($sformatf("rand_sb[%0d]", k), 64'(deliv[k][i]), 64'(sent[k][i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
